fp_div_seq: RTL

Sequential IEEE-754 single-precision divider (quotient = dividend / divisor). It computes one mantissa bit per enabled clock using radix-2 restoring division. It is the responder side of the clk_en / ready_out handshake used by the iterative math blocks (sqrt, Newton-style solvers) in the Fourier datapath. It is shared hardware, so it favours area over throughput.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_round_pack.sv | 71 +++++++
 rtl/fp_div_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the iterative math blocks.
// Holds IEEE-754 single constants, the divider state encoding and an
// operand classifier that is independent of the exponent/mantissa widths.
package fp_pkg;

  localparam int unsigned FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StDivide,
    StNormRound,
    StDone
  } div_state_e;

  typedef enum logic [1:0] {
    FpZero,
    FpNormal,
    FpInf,
    FpNan
  } fp_class_e;

  // Takes pre-reduced field flags so the caller's field widths do not matter.
  // A zero exponent is reported as zero whatever the mantissa: denormals flush.
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic man_nz);
    fp_class_e cls;
    if (exp_zero) begin
      cls = FpZero;
    end else if (exp_ones) begin
      cls = man_nz ? FpNan : FpInf;
    end else begin
      cls = FpNormal;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalize / round-to-nearest-even / clamp / pack stage.
// Ports:
//   sign_i    result sign
//   exp_i     biased exponent, two's complement, EXP_W+2 bits
//   mant_i    raw mantissa, MAN_W+3 bits, value in [0.5, 2) with the binary
//             point below the top bit
//   sticky_i  OR of all bits discarded below mant_i
//   result_o  packed IEEE word; overflow gives signed infinity, underflow
//             gives signed zero (no denormal output)
module fp_round_pack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   sign_i,
  input  logic [EXP_W+1:0]       exp_i,
  input  logic [MAN_W+2:0]       mant_i,
  input  logic                   sticky_i,
  output logic [EXP_W+MAN_W:0]   result_o
);

  localparam logic signed [EXP_W+1:0] ExpMax  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ExpZero = '0;
  localparam logic        [EXP_W+1:0] ExpOne  = (EXP_W+2)'(1);

  logic        [MAN_W+2:0] norm;
  logic signed [EXP_W+1:0] exp_n;
  logic signed [EXP_W+1:0] exp_r;
  logic        [MAN_W:0]   keep;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic        [MAN_W+1:0] sum;
  logic        [MAN_W-1:0] frac;
  logic                    unused_hidden;

  always_comb begin
    if (mant_i[MAN_W+2]) begin
      norm  = mant_i;
      exp_n = exp_i;
    end else begin
      norm  = {mant_i[MAN_W+1:0], 1'b0};
      exp_n = exp_i - ExpOne;
    end

    // Top MAN_W+1 bits are kept, next bit is guard, the last bit joins sticky.
    keep     = norm[MAN_W+2:2];
    guard    = norm[1];
    sticky   = norm[0] | sticky_i;
    round_up = guard & (sticky | keep[0]);
    sum      = {1'b0, keep} + {{(MAN_W+1){1'b0}}, round_up};

    // Carry-out only happens from all-ones, so the new fraction is zero.
    if (sum[MAN_W+1]) begin
      frac  = '0;
      exp_r = exp_n + ExpOne;
    end else begin
      frac  = sum[MAN_W-1:0];
      exp_r = exp_n;
    end
    unused_hidden = sum[MAN_W];

    if (exp_r >= ExpMax) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r <= ExpZero) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      result_o = {sign_i, exp_r[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider, one quotient bit per enabled clock
// (radix-2 restoring). Responder side of the clk_en / ready_out handshake.
// Ports:
//   clk        rising-edge clock
//   n_reset    synchronous active-low reset, wins over clk_en
//   clk_en     advance/start strobe; all state frozen while low
//   dividend   operand A, sampled only on the start edge
//   divisor    operand B, sampled only on the start edge
//   quotient   A / B, held while ready_out is high
//   ready_out  1 = idle or result valid, 0 = busy
module fp_div_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 clk_en,
  input  logic [EXP_W+MAN_W:0] dividend,
  input  logic [EXP_W+MAN_W:0] divisor,
  output logic [EXP_W+MAN_W:0] quotient,
  output logic                 ready_out
);

  import fp_pkg::*;

  localparam int unsigned        W       = 1 + EXP_W + MAN_W;
  localparam int unsigned        CntW    = $clog2(MAN_W + 3);
  localparam logic [EXP_W+1:0]   BiasW   = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic [CntW-1:0]    CntInit = CntW'(MAN_W + 2);
  localparam logic [CntW-1:0]    CntOne  = CntW'(1);

  div_state_e          state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic                sign_q, sign_d;
  logic [EXP_W+1:0]    exp_q, exp_d;
  logic [MAN_W+1:0]    rem_q, rem_d;
  logic [MAN_W:0]      dvs_q, dvs_d;
  logic [MAN_W+2:0]    quo_q, quo_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]        res_q, res_d;
  logic                ready_q, ready_d;

  logic                sign_a, sign_b, sign_r;
  logic [EXP_W-1:0]    exp_a, exp_b;
  logic [MAN_W-1:0]    man_a, man_b;
  fp_class_e           cls_a, cls_b;
  logic                is_nan, is_inf, is_zero;
  logic [MAN_W+2:0]    trial;
  logic                unused_trial;
  logic [W-1:0]        packed_res;

  assign sign_a = a_q[W-1];
  assign exp_a  = a_q[W-2:MAN_W];
  assign man_a  = a_q[MAN_W-1:0];
  assign sign_b = b_q[W-1];
  assign exp_b  = b_q[W-2:MAN_W];
  assign man_b  = b_q[MAN_W-1:0];
  assign sign_r = sign_a ^ sign_b;

  assign cls_a = fp_classify(exp_a == '0, &exp_a, |man_a);
  assign cls_b = fp_classify(exp_b == '0, &exp_b, |man_b);

  // Priority NaN > infinity > zero resolves inf/0 and 0/inf correctly.
  assign is_nan  = (cls_a == FpNan) || (cls_b == FpNan) ||
                   ((cls_a == FpZero) && (cls_b == FpZero)) ||
                   ((cls_a == FpInf) && (cls_b == FpInf));
  assign is_inf  = (cls_b == FpZero) || (cls_a == FpInf);
  assign is_zero = (cls_a == FpZero) || (cls_b == FpInf);

  // Sign bit of trial is the borrow: set means remainder < divisor.
  assign trial        = {1'b0, rem_q} - {2'b00, dvs_q};
  assign unused_trial = trial[MAN_W+1];

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .mant_i   (quo_q),
    .sticky_i (|rem_q),
    .result_o (packed_res)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ready_d = ready_q;

    unique case (state_q)
      StIdle, StDone: begin
        a_d     = dividend;
        b_d     = divisor;
        ready_d = 1'b0;
        state_d = StUnpack;
      end
      StUnpack: begin
        sign_d = sign_r;
        if (is_nan) begin
          res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          ready_d = 1'b1;
          state_d = StDone;
        end else if (is_inf) begin
          res_d   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ready_d = 1'b1;
          state_d = StDone;
        end else if (is_zero) begin
          res_d   = {sign_r, {(EXP_W+MAN_W){1'b0}}};
          ready_d = 1'b1;
          state_d = StDone;
        end else begin
          exp_d   = {2'b00, exp_a} - {2'b00, exp_b} + BiasW;
          rem_d   = {1'b0, 1'b1, man_a};
          dvs_d   = {1'b1, man_b};
          quo_d   = '0;
          cnt_d   = CntInit;
          state_d = StDivide;
        end
      end
      StDivide: begin
        // Restored remainder is always below the divisor, so its top bit is
        // zero and the left shift cannot lose information.
        if (!trial[MAN_W+2]) begin
          rem_d = {trial[MAN_W:0], 1'b0};
          quo_d = {quo_q[MAN_W+1:0], 1'b1};
        end else begin
          rem_d = {rem_q[MAN_W:0], 1'b0};
          quo_d = {quo_q[MAN_W+1:0], 1'b0};
        end
        cnt_d = cnt_q - CntOne;
        if (cnt_q == '0) begin
          state_d = StNormRound;
        end
      end
      StNormRound: begin
        res_d   = packed_res;
        ready_d = 1'b1;
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
    end else if (clk_en) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ready_q <= ready_d;
    end
  end

  assign quotient  = res_q;
  assign ready_out = ready_q;

endmodule
